// File: rtl/ogpu_raster_cmd_sequencer.sv
// Raster command sequencer: decodes toggle-tagged PIO command bytes, queues them, issues to the engine.
// Optional watchdog enabled with `define OGPU_CMD_WATCHDOG_EN (limit set by WDT_CYCLES).
module ogpu_raster_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WDT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] command,
  output logic [2:0] eng_op,
  output logic [3:0] eng_arg,
  output logic       eng_valid,
  input  logic       eng_ready,
  input  logic       eng_done,
  output logic [7:0] status
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t           state_reg;
  logic             prev_toggle_reg;
  logic [6:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             illegal_reg;
  logic             timeout_reg;
  logic [2:0]       done_cnt_reg;

  logic       new_cmd;
  logic [2:0] cmd_op;
  logic       is_abort;
  logic       is_illegal;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       wdt_expire;

  assign new_cmd    = command[7] ^ prev_toggle_reg;
  assign cmd_op     = command[6:4];
  assign is_abort   = new_cmd && (cmd_op == 3'd7);
  assign is_illegal = new_cmd && ((cmd_op == 3'd5) || (cmd_op == 3'd6));
  assign push_req   = new_cmd && (cmd_op != 3'd0) && (cmd_op <= 3'd4);
  assign pop        = (state_reg == IDLE) && (count_reg != '0);
  // A full queue still takes a command when the head leaves on the same edge.
  assign push       = push_req && ((count_reg != DEPTH_C) || pop);

`ifdef OGPU_CMD_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt_reg;

  assign wdt_expire = (state_reg != IDLE) && (wdt_cnt_reg == WDT_W'(WDT_CYCLES - 1));

  // Idle always holds the counter at zero, so each ISSUE/WAIT_DONE entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset || (state_reg == IDLE) || ((state_reg == ISSUE) && eng_ready)) begin
      wdt_cnt_reg <= '0;
    end else begin
      wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES == 0);
  assign wdt_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr_reg] <= command[6:0];
    end
  end

  always_ff @(posedge clk) begin
    // Resampled under reset too, so a toggle held across reset is not a command.
    prev_toggle_reg <= command[7];
    if (reset) begin
      state_reg    <= IDLE;
      eng_valid    <= 1'b0;
      eng_op       <= '0;
      eng_arg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      done_cnt_reg <= '0;
    end else if (is_abort) begin
      state_reg    <= IDLE;
      eng_valid    <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      done_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (push_req && !push) begin
        overflow_reg <= 1'b1;
      end
      if (is_illegal) begin
        illegal_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (pop) begin
            eng_op    <= fifo_mem[rd_ptr_reg][6:4];
            eng_arg   <= fifo_mem[rd_ptr_reg][3:0];
            eng_valid <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_ready) begin
            eng_valid <= 1'b0;
            state_reg <= WAIT_DONE;
          end else if (wdt_expire) begin
            eng_valid   <= 1'b0;
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (eng_done) begin
            done_cnt_reg <= done_cnt_reg + 1'b1;
            state_reg    <= IDLE;
          end else if (wdt_expire) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: begin
          eng_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign status = {done_cnt_reg, timeout_reg, illegal_reg, overflow_reg,
                   (count_reg == DEPTH_C),
                   ((state_reg != IDLE) || (count_reg != '0))};

endmodule

// File: tb/tb_ogpu_raster_cmd_sequencer.sv
// Bench for ogpu_raster_cmd_sequencer: directed test-plan steps, then random traffic vs a queue model.
`timescale 1ns/1ps
module tb_ogpu_raster_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int WDT   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] command;
  logic [2:0] eng_op;
  logic [3:0] eng_arg;
  logic       eng_valid;
  logic       eng_ready;
  logic       eng_done;
  logic [7:0] status;

  int tests = 0;
  int fails = 0;

  ogpu_raster_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .reset(reset), .command(command),
    .eng_op(eng_op), .eng_arg(eng_arg), .eng_valid(eng_valid),
    .eng_ready(eng_ready), .eng_done(eng_done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a queue of pending {op,arg}, plus where the engine conversation stands
  // (0 = nothing outstanding, 1 = offer on the wire, 2 = accepted, waiting for done).
  int  q[$];
  bit  m_prev;
  bit  m_live = 1'b0;
  int  m_phase = 0;
  int  m_offer = 0;
  int  m_age = 0;
  int  m_done = 0;
  bit  m_ovf, m_ill, m_to;

  function automatic logic [7:0] m_status();
    return {3'(m_done), m_to, m_ill, m_ovf, (q.size() == DEPTH), ((m_phase != 0) || (q.size() != 0))};
  endfunction

  task automatic wdt_tick();
    m_age++;
`ifdef OGPU_CMD_WATCHDOG_EN
    if (m_age == WDT) begin
      m_to    = 1'b1;
      m_phase = 0;
    end
`endif
  endtask

  always @(posedge clk) begin : model
    logic [2:0] op;
    bit nc;
    bit popping;
    int head;
    op = command[6:4];
    nc = (command[7] != m_prev);
    m_prev = command[7];
    if (reset) begin
      q.delete();
      m_phase = 0; m_age = 0; m_done = 0;
      m_ovf = 1'b0; m_ill = 1'b0; m_to = 1'b0;
      m_live = 1'b1;
    end else if (nc && op == 3'd7) begin
      q.delete();
      m_phase = 0; m_done = 0;
      m_ovf = 1'b0; m_ill = 1'b0; m_to = 1'b0;
    end else begin
      popping = (m_phase == 0) && (q.size() > 0);
      head = 0;
      if (popping) head = q.pop_front();
      if (nc && op >= 3'd1 && op <= 3'd4) begin
        if (q.size() < DEPTH) q.push_back(int'(command[6:0]));
        else m_ovf = 1'b1;
      end
      if (nc && (op == 3'd5 || op == 3'd6)) m_ill = 1'b1;
      case (m_phase)
        0: if (popping) begin
          m_offer = head; m_phase = 1; m_age = 0;
        end
        1: if (eng_ready) begin
          m_phase = 2; m_age = 0;
          $display("[TB] engine accepted op=%0d arg=%0d", m_offer >> 4, m_offer & 15);
        end else begin
          wdt_tick();
        end
        default: if (eng_done) begin
          m_done = (m_done + 1) % 8; m_phase = 0;
        end else begin
          wdt_tick();
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_eng_valid", eng_valid, (m_phase == 1));
      chk("cyc_status", status, m_status());
      if (m_phase == 1) chk("cyc_eng_cmd", {eng_op, eng_arg}, m_offer);
    end
  end

  bit tgl;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] arg);
    tgl = ~tgl;
    command = {tgl, op, arg};
  endtask

  initial begin
    int r;
    int rop;
    reset = 1'b1; command = 8'h80; tgl = 1'b1; eng_ready = 1'b0; eng_done = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    $display("[TB] t1 reset with toggle held high");
    chk("t1_reset_valid", eng_valid, 0);
    chk("t1_reset_status", status, 8'h00);

    send(3'd2, 4'd5);
    $display("[TB] t1 command 0x%02h", command);
    cyc(1);
    chk("t1_n1_valid", eng_valid, 0);
    cyc(1);
    chk("t1_n2_valid", eng_valid, 1);
    chk("t1_op", eng_op, 2);
    chk("t1_arg", eng_arg, 5);
    chk("t1_busy", status[0], 1);

    $display("[TB] t2 stall then handshake and done");
    cyc(10);
    chk("t2_hold", {eng_valid, eng_op, eng_arg}, 8'h25 | 8'h80);
    eng_ready = 1'b1; cyc(1); eng_ready = 1'b0;
    chk("t2_valid_drop", eng_valid, 0);
    chk("t2_wait_status", status, 8'h01);
    cyc(2);
    eng_done = 1'b1; cyc(1); eng_done = 1'b0;
    chk("t2_done_status", status, 8'h20);
    eng_done = 1'b1; cyc(1); eng_done = 1'b0;
    chk("t2_stray_done", status, 8'h20);

    $display("[TB] t4 illegal then nop");
    send(3'd5, 4'd0); cyc(3);
    send(3'd0, 4'd0); cyc(3);
    chk("t4_status", status, 8'h28);
    chk("t4_valid", eng_valid, 0);

    $display("[TB] t3 six commands with engine stalled");
    for (int i = 0; i < 6; i++) begin
      send(3'd1, 4'(i));
      cyc(4);
    end
    chk("t3_status_lo", status[2:0], 3'b111);
    chk("t3_status", status, 8'h2F);
    chk("t3_head_arg", eng_arg, 0);

    for (int k = 0; k < 2; k++) begin
      eng_ready = 1'b1; cyc(1); eng_ready = 1'b0;
      cyc(1);
      eng_done = 1'b1; cyc(1); eng_done = 1'b0;
      cyc(1);
    end
    eng_ready = 1'b1; cyc(1); eng_ready = 1'b0;
    chk("t5_pre_abort", status, 8'h6D);

    $display("[TB] t5 abort in WAIT_DONE");
    send(3'd7, 4'd0); cyc(1);
    chk("t5_abort_status", status, 8'h00);
    chk("t5_abort_valid", eng_valid, 0);
    eng_done = 1'b1; cyc(1); eng_done = 1'b0;
    chk("t5_late_done", status[7:5], 0);

    $display("[TB] t6 engine never completes");
    send(3'd3, 4'd1); cyc(1);
    send(3'd4, 4'd2); cyc(1);
    eng_ready = 1'b1; cyc(1); eng_ready = 1'b0;
`ifdef OGPU_CMD_WATCHDOG_EN
    cyc(15);
    chk("t6_no_timeout_yet", status[4], 0);
    cyc(1);
    chk("t6_timeout", status[4], 1);
    cyc(1);
    chk("t6_next_valid", eng_valid, 1);
    chk("t6_next_cmd", {eng_op, eng_arg}, 7'h42);
`else
    cyc(1000);
    chk("t6_still_busy", status[0], 1);
    chk("t6_no_timeout", status[4], 0);
    chk("t6_valid_low", eng_valid, 0);
`endif
    send(3'd7, 4'd0); cyc(1);
    chk("t6_abort_clears", status, 8'h00);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 15);
      if (r < 3) begin
        rop = $urandom_range(0, 7);
        if (rop == 7 && $urandom_range(0, 3) != 0) rop = 1;
        send(3'(rop), 4'($urandom));
      end else if (r == 3) begin
        command[6:0] = 7'($urandom);
      end
      eng_ready = ($urandom_range(0, 2) == 0);
      eng_done  = ($urandom_range(0, 3) == 0);
      if (c == 1500) reset = 1'b1;
      if (c == 1502) reset = 1'b0;
      cyc(1);
    end
    eng_ready = 1'b0; eng_done = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
